// File: rtl/sc_sobol_stream_tx.sv
// Stochastic-number transmitter: normalises a binary operand to a short mantissa and
// streams it as a unipolar bitstream compared against a van der Corput (Sobol) sequence.
module sc_sobol_stream_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SOBOL_BITS = 5,
    parameter int EXP_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [SOBOL_BITS-1:0] out_mant,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, NORM, STREAM} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d, lz;
    logic [SOBOL_BITS-1:0] mant_q, mant_d, mant_n;
    logic [SOBOL_BITS-1:0] idx_q, idx_d, sobol;
    logic                  in_ready_q;
    logic                  found;

    // Leading-zero count; a zero operand leaves lz at 0 and yields a zero mantissa.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (!found && data_q[DATA_WIDTH-1-i]) begin
                lz    = EXP_WIDTH'(i);
                found = 1'b1;
            end
        end
        mant_n = SOBOL_BITS'((data_q << lz) >> (DATA_WIDTH - SOBOL_BITS));
    end

    always_comb begin
        sobol = '0;
        for (int unsigned i = 0; i < SOBOL_BITS; i++) begin
            sobol[i] = idx_q[SOBOL_BITS-1-i];
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    state_d = NORM;
                end
            end
            NORM: begin
                exp_d   = lz;
                mant_d  = mant_n;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_bit   = (mant_q > sobol);
                out_last  = (idx_q == '1);
                if (out_ready) begin
                    if (idx_q == '1) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + SOBOL_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it is low for the reset cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            idx_q      <= idx_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    assign in_ready = in_ready_q;
    assign out_exp  = exp_q;
    assign out_mant = mant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sc_sobol_stream_tx.sv
// Randomised bench for sc_sobol_stream_tx against an arithmetic model of normalisation
// and van der Corput comparison.
module tb_sc_sobol_stream_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_bit;
    logic        out_last;
    logic [3:0]  out_exp;
    logic [4:0]  out_mant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic bb[32];
    logic bl[32];
    int   be[32];
    int   bm[32];
    int   nbeats, stall_chg, rdy_hi, ncyc;
    bit   timeout_flag;

    sc_sobol_stream_tx #(
        .DATA_WIDTH(16),
        .SOBOL_BITS(5),
        .EXP_WIDTH (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_last (out_last),
        .out_exp  (out_exp),
        .out_mant (out_mant),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic int model_exp(input int v);
        int e = 0;
        int t = v;
        if (v == 0) return 0;
        while (t < 32768) begin
            t = t * 2;
            e++;
        end
        return e;
    endfunction

    function automatic int model_mant(input int v);
        int t = v;
        if (v == 0) return 0;
        while (t < 32768) t = t * 2;
        return t / 2048;
    endfunction

    function automatic int vdc(input int k);
        int r = 0;
        for (int j = 0; j < 5; j++) r = r * 2 + ((k >> j) & 1);
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [15:0] v, output int waited);
        in_valid = 1'b1;
        in_data  = v;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Records every handshaken beat plus stall/in_ready observations until the last beat.
    task automatic collect(input bit rand_ready, input bit hold_valid);
        bit   stalled = 0;
        bit   done = 0;
        logic pb = 0;
        logic pl = 0;
        for (int k = 0; k < 32; k++) begin
            bb[k] = 1'bx; bl[k] = 1'bx; be[k] = -1; bm[k] = -1;
        end
        nbeats = 0; stall_chg = 0; rdy_hi = 0; ncyc = 0; timeout_flag = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            if (in_ready === 1'b1) rdy_hi++;
            if (out_valid === 1'b1) begin
                if (stalled && (out_bit !== pb || out_last !== pl)) stall_chg++;
                pb = out_bit;
                pl = out_last;
                stalled = !out_ready;
                if (out_ready) begin
                    if (nbeats < 32) begin
                        bb[nbeats] = out_bit;
                        bl[nbeats] = out_last;
                        be[nbeats] = int'(out_exp);
                        bm[nbeats] = int'(out_mant);
                    end
                    nbeats++;
                    if (out_last === 1'b1 || nbeats >= 40) done = 1;
                end
            end
            step();
            ncyc++;
            if (done) begin
                timeout_flag = (nbeats >= 40);
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h8000; out_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({in_ready, out_valid, out_bit, out_last, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/vld/bit/last/busy=%b want 00000",
                     {in_ready, out_valid, out_bit, out_last, busy});
        end
        checks++;
        if (out_exp !== 4'd0 || out_mant !== 5'd0) begin
            errors++;
            $display("FAIL reset_side got exp=%0d mant=%0d want 0 0", out_exp, out_mant);
        end
        reset = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_latency();
        int w;
        out_ready = 1'b0;
        accept(16'h8000, w);
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b010) begin
            errors++;
            $display("FAIL latency_norm got vld/busy/rdy=%b want 010", {out_valid, busy, in_ready});
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_exp !== 4'd0 || out_mant !== 5'd16 || out_bit !== 1'b1) begin
            errors++;
            $display("FAIL latency_first got vld=%b exp=%0d mant=%0d bit=%b want 1 0 16 1",
                     out_valid, out_exp, out_mant, out_bit);
        end
        collect(0, 0);
        checks++;
        if (timeout_flag || nbeats !== 32) begin
            errors++;
            $display("FAIL latency_drain got beats=%0d want 32", nbeats);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] vals[$];
        int w, m, e, ones, bad, lbad, sbad;
        vals = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0C00, 16'h0001};
        for (int i = 0; i < 6; i++) vals.push_back(16'($urandom) >> $urandom_range(0, 15));
        foreach (vals[i]) begin
            m = model_mant(int'(vals[i]));
            e = model_exp(int'(vals[i]));
            accept(vals[i], w);
            collect(i >= 5, 0);
            ones = 0; bad = 0; lbad = 0; sbad = 0;
            for (int k = 0; k < 32; k++) begin
                ones += int'(bb[k] === 1'b1);
                if (bb[k] !== (m > vdc(k))) bad++;
                if (bl[k] !== (k == 31)) lbad++;
                if (be[k] !== e || bm[k] !== m) sbad++;
            end
            checks++;
            if (timeout_flag || nbeats !== 32) begin
                errors++;
                $display("FAIL pat_beats %h got %0d want 32", vals[i], nbeats);
            end
            checks++;
            if (ones !== m) begin
                errors++;
                $display("FAIL pat_ones %h got %0d want %0d", vals[i], ones, m);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL pat_bits %h got %0d wrong beats want 0", vals[i], bad);
            end
            checks++;
            if (lbad !== 0) begin
                errors++;
                $display("FAIL pat_last %h got %0d wrong beats want 0", vals[i], lbad);
            end
            checks++;
            if (sbad !== 0) begin
                errors++;
                $display("FAIL pat_side %h got exp=%0d mant=%0d want %0d %0d",
                         vals[i], be[0], bm[0], e, m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals[2];
        int w, m, e, ones, sbad;
        vals = '{16'h0001, 16'h4000};
        for (int i = 0; i < 2; i++) begin
            m = model_mant(int'(vals[i]));
            e = model_exp(int'(vals[i]));
            accept(vals[i], w);
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL b2b_accept_wait %h got %0d want 0", vals[i], w);
            end
            collect(0, 0);
            checks++;
            if (timeout_flag || nbeats !== 32 || ncyc !== 33) begin
                errors++;
                $display("FAIL b2b_timing %h got beats=%0d cycles=%0d want 32 33", vals[i], nbeats, ncyc);
            end
            ones = 0; sbad = 0;
            for (int k = 0; k < 32; k++) begin
                ones += int'(bb[k] === 1'b1);
                if (be[k] !== e || bm[k] !== m) sbad++;
            end
            checks++;
            if (ones !== 16 || sbad !== 0) begin
                errors++;
                $display("FAIL b2b_stream %h got ones=%0d exp=%0d mant=%0d want 16 %0d %0d",
                         vals[i], ones, be[0], bm[0], e, m);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_after %h got %b want 1", vals[i], in_ready);
            end
        end
    endtask

    task automatic test_stall();
        int w, ones, bad;
        out_ready = 1'b0;
        accept(16'h8000, w);
        collect(1, 1);
        in_valid = 1'b0;
        ones = 0; bad = 0;
        for (int k = 0; k < 32; k++) begin
            ones += int'(bb[k] === 1'b1);
            if (bb[k] !== (16 > vdc(k)) || bl[k] !== (k == 31)) bad++;
        end
        checks++;
        if (timeout_flag || nbeats !== 32 || ones !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL stall_stream got beats=%0d ones=%0d badbeats=%0d want 32 16 0", nbeats, ones, bad);
        end
        checks++;
        if (stall_chg !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d changes want 0", stall_chg);
        end
        checks++;
        if (rdy_hi !== 0) begin
            errors++;
            $display("FAIL stall_in_ready got %0d high cycles want 0", rdy_hi);
        end
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_capture got busy=%b in_ready=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_stream();
        int w, ones, bad;
        out_ready = 1'b1;
        accept(16'hFFFF, w);
        repeat (11) step();
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_last !== 1'b0 || out_mant !== 5'd31) begin
            errors++;
            $display("FAIL midrst_beat10 got vld=%b bit=%b last=%b mant=%0d want 1 1 0 31",
                     out_valid, out_bit, out_last, out_mant);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({out_valid, busy, out_last, out_bit, in_ready} !== 5'b0 || out_exp !== 4'd0 || out_mant !== 5'd0) begin
            errors++;
            $display("FAIL midrst_outputs got vld/busy/last/bit/rdy=%b exp=%0d mant=%0d want 00000 0 0",
                     {out_valid, busy, out_last, out_bit, in_ready}, out_exp, out_mant);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready got in_ready=%b last=%b want 1 0", in_ready, out_last);
        end
        accept(16'h4000, w);
        collect(0, 0);
        ones = 0; bad = 0;
        for (int k = 0; k < 32; k++) begin
            ones += int'(bb[k] === 1'b1);
            if (bb[k] !== (16 > vdc(k)) || bl[k] !== (k == 31) || be[k] !== 1 || bm[k] !== 16) bad++;
        end
        checks++;
        if (timeout_flag || nbeats !== 32 || ones !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL midrst_next got beats=%0d ones=%0d badbeats=%0d want 32 16 0", nbeats, ones, bad);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_back_to_back();
        test_stall();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
